result_display: RTL and testbench

Output stage that sits directly downstream of the 3-bit sign-magnitude adder. It accepts one 4-bit sign-magnitude result plus zero flag per valid/ready handshake. It holds the captured value for a guaranteed minimum time, then drives a two-digit time-multiplexed active-low 7-segment display (sign digit, magnitude digit) and two status LEDs.

---
 rtl/result_display.sv | 152 +++++++++++++++
 tb/tb_result_display.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_display.sv
// Output stage for the sign-magnitude adder: captures one result per handshake,
// holds it, and drives a two-digit multiplexed active-low 7-segment display.
module result_display #(
  parameter int REFRESH_DIV = 1000,
  parameter int HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_result,
  input  logic       in_zero,
  input  logic       clr,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       led_neg,
  output logic       led_zero
);

  localparam int REF_W  = $clog2(REFRESH_DIV);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {IDLE, HOLD, SHOW} state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [REF_W-1:0]  refresh_q, refresh_d;
  logic              idx_q, idx_d;
  logic              sign_q, sign_d;
  logic [2:0]        mag_q, mag_d;
  logic              zero_q, zero_d;
  logic              in_ready_q, in_ready_d;
  logic [6:0]        seg_q, seg_d;
  logic [1:0]        an_q, an_d;
  logic              led_neg_q, led_neg_d;
  logic              led_zero_q, led_zero_d;

  logic              accept;
  logic              cap_zero;
  logic              showing;
  logic [6:0]        mag_seg;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    zero_d    = zero_q;
    accept    = in_valid & in_ready_q;
    cap_zero  = in_zero | (in_result[2:0] == 3'd0);

    refresh_d = (refresh_q == REF_LAST) ? '0 : refresh_q + 1'b1;
    idx_d     = (refresh_q == REF_LAST) ? ~idx_q : idx_q;

    // clr has priority over a same-edge accept and drops the captured value
    if (clr) begin
      state_d = IDLE;
      hold_d  = '0;
      sign_d  = 1'b0;
      mag_d   = 3'd0;
      zero_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE, SHOW: begin
          if (accept) begin
            state_d = HOLD;
            hold_d  = '0;
            mag_d   = in_result[2:0];
            zero_d  = cap_zero;
            sign_d  = in_result[3] & ~cap_zero;
          end
        end
        HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_d = SHOW;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    in_ready_d = (state_d != HOLD);

    case (mag_q)
      3'd0:    mag_seg = 7'b1000000;
      3'd1:    mag_seg = 7'b1111001;
      3'd2:    mag_seg = 7'b0100100;
      3'd3:    mag_seg = 7'b0110000;
      3'd4:    mag_seg = 7'b0011001;
      3'd5:    mag_seg = 7'b0010010;
      3'd6:    mag_seg = 7'b0000010;
      default: mag_seg = 7'b1111000;
    endcase

    // Display lags state by one edge so seg and an always switch together
    showing    = (state_q != IDLE);
    an_d       = idx_q ? 2'b01 : 2'b10;
    if (!showing)
      seg_d = SEG_BLANK;
    else if (idx_q)
      seg_d = sign_q ? SEG_MINUS : SEG_BLANK;
    else
      seg_d = mag_seg;
    led_neg_d  = showing & sign_q;
    led_zero_d = showing & zero_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      refresh_q  <= '0;
      idx_q      <= 1'b0;
      sign_q     <= 1'b0;
      mag_q      <= 3'd0;
      zero_q     <= 1'b1;
      in_ready_q <= 1'b0;
      seg_q      <= SEG_BLANK;
      an_q       <= 2'b11;
      led_neg_q  <= 1'b0;
      led_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      refresh_q  <= refresh_d;
      idx_q      <= idx_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      zero_q     <= zero_d;
      in_ready_q <= in_ready_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      led_neg_q  <= led_neg_d;
      led_zero_q <= led_zero_d;
    end
  end

  assign in_ready = in_ready_q;
  assign seg      = seg_q;
  assign an       = an_q;
  assign led_neg  = led_neg_q;
  assign led_zero = led_zero_q;

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display: random and directed stimulus compared
// against a cycle-level behavioural model of the display.
module tb_result_display;

  localparam int REF  = 4;
  localparam int HOLD = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_result;
  logic       in_zero;
  logic       clr;
  logic [6:0] seg;
  logic [1:0] an;
  logic       led_neg;
  logic       led_zero;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  int         edge_cnt;
  int         ready_from;
  bit         mdl_ready;
  bit         cap_valid, cap_neg, cap_zero;
  bit [2:0]   cap_mag;
  bit         disp_valid, disp_neg, disp_zero;
  bit [2:0]   disp_mag;
  bit         last_acc;
  logic [1:0] exp_an;
  logic [6:0] exp_seg;
  logic [12:0] exp_vec;
  logic [12:0] obs_vec;

  result_display #(.REFRESH_DIV(REF), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_zero(in_zero), .clr(clr),
    .seg(seg), .an(an), .led_neg(led_neg), .led_zero(led_zero)
  );

  always #5 clk = ~clk;

  assign obs_vec = {seg, an, in_ready, led_neg, led_zero};

  function automatic logic [6:0] digit(input bit [2:0] m);
    logic [6:0] t [8];
    t[0] = 7'b1000000; t[1] = 7'b1111001; t[2] = 7'b0100100; t[3] = 7'b0110000;
    t[4] = 7'b0011001; t[5] = 7'b0010010; t[6] = 7'b0000010; t[7] = 7'b1111000;
    return t[m];
  endfunction

  task automatic model_reset();
    edge_cnt   = 0;
    ready_from = 0;
    mdl_ready  = 1'b0;
    cap_valid  = 1'b0;
    disp_valid = 1'b0;
    last_acc   = 1'b0;
  endtask

  // One clock: drive inputs, advance to just after the edge, update the model
  task automatic tick(input logic v, input logic [3:0] r, input logic z, input logic c);
    bit acc;
    in_valid  = v;
    in_result = r;
    in_zero   = z;
    clr       = c;
    acc = v && mdl_ready && !c;
    @(posedge clk);
    #1;
    edge_cnt++;
    disp_valid = cap_valid;
    disp_neg   = cap_neg;
    disp_zero  = cap_zero;
    disp_mag   = cap_mag;
    if (c) begin
      cap_valid  = 1'b0;
      ready_from = edge_cnt;
    end else if (acc) begin
      cap_valid  = 1'b1;
      cap_mag    = r[2:0];
      cap_zero   = z || (r[2:0] == 3'd0);
      cap_neg    = r[3] && !cap_zero;
      ready_from = edge_cnt + HOLD;
    end
    mdl_ready = (edge_cnt >= ready_from);
    exp_an    = ((((edge_cnt - 1) / REF) % 2) == 0) ? 2'b10 : 2'b01;
    if (!disp_valid)          exp_seg = 7'b1111111;
    else if (exp_an == 2'b10) exp_seg = digit(disp_mag);
    else                      exp_seg = disp_neg ? 7'b0111111 : 7'b1111111;
    exp_vec  = {exp_seg, exp_an, mdl_ready, disp_valid && disp_neg, disp_valid && disp_zero};
    last_acc = acc;
  endtask

  task automatic test_reset();
    in_valid = 0; in_result = 0; in_zero = 0; clr = 0;
    rst = 1'b1;
    model_reset();
    #13;
    n_cmp++;
    if (obs_vec !== 13'b1111111_11_0_0_0) begin
      n_fail++;
      $display("[TB] FAIL reset_vals got=%b want=%b", obs_vec, 13'b1111111_11_0_0_0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 4'($urandom), 1'($urandom), 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL idle_scan edge=%0d got=%b want=%b", edge_cnt, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_negative();
    tick(1'b1, 4'b1101, 1'b0, 1'b0);
    n_cmp++;
    if (last_acc !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL neg_accept got_ready=%b want=0", in_ready);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 4'b0000, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL negative edge=%0d got=%b want=%b", edge_cnt, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_acc = 0;
    int low_run = 0;
    int first_low = -1;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, (n_acc == 0) ? 4'b0011 : 4'b0110, 1'b0, 1'b0);
      if (last_acc) n_acc++;
      if (n_acc == 1 && in_ready === 1'b0) low_run++;
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL back_to_back edge=%0d got=%b want=%b", edge_cnt, obs_vec, exp_vec);
      end
      if (first_low < 0 && in_ready === 1'b0) first_low = edge_cnt;
    end
    n_cmp++;
    if (low_run != HOLD) begin
      n_fail++;
      $display("[TB] FAIL hold_len got=%0d want=%0d", low_run, HOLD);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 4'b0000, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL b2b_show edge=%0d got=%b want=%b", edge_cnt, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_neg_zero();
    tick(1'b1, 4'b1000, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 4'b0000, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL neg_zero edge=%0d got=%b want=%b", edge_cnt, obs_vec, exp_vec);
      end
    end
    n_cmp++;
    if (led_zero !== 1'b1 || led_neg !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL neg_zero_leds got=%b%b want=10", led_zero, led_neg);
    end
  endtask

  task automatic test_clear();
    tick(1'b1, 4'b1010, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick(1'b0, 4'b0000, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL clear edge=%0d got=%b want=%b", edge_cnt, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, 4'b1110, 1'b0, 1'b0);
    tick(1'b0, 4'b0000, 1'b0, 1'b0);
    n_cmp++;
    if (obs_vec !== exp_vec) begin
      n_fail++;
      $display("[TB] FAIL pre_async edge=%0d got=%b want=%b", edge_cnt, obs_vec, exp_vec);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs_vec !== 13'b1111111_11_0_0_0) begin
      n_fail++;
      $display("[TB] FAIL async_reset got=%b want=%b", obs_vec, 13'b1111111_11_0_0_0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 4'b0000, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL post_async edge=%0d got=%b want=%b", edge_cnt, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      tick(1'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 11) == 0));
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL random edge=%0d got=%b want=%b", edge_cnt, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_negative();
    test_back_to_back();
    test_neg_zero();
    test_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
